// File: rtl/pitch_game_pkg.sv
// Shared types and defaults for the voice-controlled wall game.
// Timing defaults describe standard 640x480 VGA.
package pitch_game_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_RED   = 12'hF00;
  localparam rgb_t RGB_GREEN = 12'h0F0;
  localparam rgb_t RGB_BLUE  = 12'h00F;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/pitch_game_vga_timing.sv
// Pixel-enable divider, raster counters and active-low syncs.
// Syncs decode the counters directly so they line up with xpos/ypos.
module vga_timing
  import pitch_game_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic       clk,
  input  logic       resetNot,
  output logic       pix_en,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk or negedge resetNot) begin
    if (!resetNot) begin
      pix_en <= 1'b0;
      xpos   <= '0;
      ypos   <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (xpos == X_LAST) begin
          xpos <= '0;
          ypos <= (ypos == Y_LAST) ? '0 : ypos + 10'd1;
        end else begin
          xpos <= xpos + 10'd1;
        end
      end
    end
  end

  assign hsync = !(xpos >= HS_FIRST && xpos <= HS_LAST);
  assign vsync = !(ypos >= VS_FIRST && ypos <= VS_LAST);

endmodule

// File: rtl/pitch_game_top.sv
// Voice-controlled wall game: mic pitch sets player height, wall scrolls
// left once per frame, VGA colour is decoded from counters and game state.
module pitch_game_top
  import pitch_game_pkg::*;
#(
  parameter int H_VISIBLE     = H_VISIBLE_DEF,
  parameter int H_FP          = H_FP_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BP          = H_BP_DEF,
  parameter int V_VISIBLE     = V_VISIBLE_DEF,
  parameter int V_FP          = V_FP_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BP          = V_BP_DEF,
  parameter int WINDOW_CYCLES = 1048576,
  parameter int PITCH_SHIFT   = 2,
  parameter int PLAYER_X      = 100,
  parameter int PLAYER_SIZE   = 16,
  parameter int WALL_W        = 16,
  parameter int GAP_H         = 128,
  parameter int GAP_MIN       = 32
) (
  input  logic       clk,
  input  logic       resetNot,
  input  logic       start_button_not,
  input  logic       mic_clk,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int WIN_W    = $clog2(WINDOW_CYCLES);
  localparam int FLOOR_Y  = V_VISIBLE - 1 - PLAYER_SIZE;
  localparam int GAP_SPAN = V_VISIBLE - GAP_H - 2 * GAP_MIN;
  localparam int HW       = 16 + PITCH_SHIFT;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [9:0] WALL_START = 10'(H_VISIBLE - 1);
  localparam logic [9:0] GAP_RESET  = 10'((V_VISIBLE - GAP_H) / 2);

  logic             pix_en, frame_tick, out_en;
  logic [1:0]       btn_sync, mic_sync;
  logic             btn_prev, press, mic_prev, mic_rise;
  logic [WIN_W-1:0] win_cnt;
  logic [15:0]      edge_cnt, pitch_count;
  logic [HW-1:0]    h_raw;
  logic [9:0]       h_clamp, player_y, wall_x, gap_y;
  logic [7:0]       lfsr, lfsr_next;
  logic             wall_hit_x, in_gap, collide, visible, in_player, in_wall;
  state_t           state, state_next;
  rgb_t             pix;

  function automatic logic [9:0] gap_from(input logic [7:0] s);
    return 10'(GAP_MIN) + 10'(s) % 10'(GAP_SPAN);
  endfunction

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_vga (
    .clk(clk), .resetNot(resetNot), .pix_en(pix_en),
    .xpos(xpos), .ypos(ypos), .hsync(hsync), .vsync(vsync)
  );

  // Button idles high, so its synchroniser resets high to avoid a false press.
  always_ff @(posedge clk or negedge resetNot) begin
    if (!resetNot) begin
      btn_sync <= 2'b11;
      btn_prev <= 1'b1;
      mic_sync <= 2'b00;
      mic_prev <= 1'b0;
      out_en   <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], start_button_not};
      btn_prev <= btn_sync[1];
      mic_sync <= {mic_sync[0], mic_clk};
      mic_prev <= mic_sync[1];
      out_en   <= 1'b1;
    end
  end

  assign press    = btn_prev & ~btn_sync[1];
  assign mic_rise = mic_sync[1] & ~mic_prev;

  // An edge landing on the window-end cycle seeds the next window.
  always_ff @(posedge clk or negedge resetNot) begin
    if (!resetNot) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      pitch_count <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt     <= '0;
      pitch_count <= edge_cnt;
      edge_cnt    <= {15'd0, mic_rise};
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      if (mic_rise && edge_cnt != 16'hFFFF) edge_cnt <= edge_cnt + 16'd1;
    end
  end

  assign h_raw    = HW'(pitch_count) << PITCH_SHIFT;
  assign h_clamp  = (h_raw > HW'(FLOOR_Y)) ? 10'(FLOOR_Y) : h_raw[9:0];
  assign player_y = 10'(FLOOR_Y) - h_clamp;

  assign frame_tick = pix_en && xpos == '0 && ypos == 10'(V_VISIBLE);
  assign lfsr_next  = lfsr_step(lfsr);

  assign wall_hit_x = ({1'b0, wall_x} < 11'(PLAYER_X + PLAYER_SIZE)) &&
                      ({1'b0, wall_x} + 11'(WALL_W) > 11'(PLAYER_X));
  assign in_gap     = (player_y >= gap_y) &&
                      ({1'b0, player_y} + 11'(PLAYER_SIZE) <= {1'b0, gap_y} + 11'(GAP_H));
  assign collide    = wall_hit_x && !in_gap;

  always_ff @(posedge clk or negedge resetNot) begin
    if (!resetNot) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (press) state_next = PLAY;
      PLAY:    if (frame_tick && collide) state_next = OVER;
      OVER:    if (press) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetNot) begin
    if (!resetNot) begin
      wall_x <= WALL_START;
      gap_y  <= GAP_RESET;
      lfsr   <= LFSR_SEED;
    end else if (state == IDLE && press) begin
      wall_x <= WALL_START;
      gap_y  <= gap_from(lfsr);
    end else if (state == PLAY && frame_tick) begin
      if (wall_x == '0) begin
        wall_x <= WALL_START;
        lfsr   <= lfsr_next;
        gap_y  <= gap_from(lfsr_next);
      end else begin
        wall_x <= wall_x - 10'd1;
      end
    end
  end

  assign visible   = xpos < 10'(H_VISIBLE) && ypos < 10'(V_VISIBLE);
  assign in_player = xpos >= 10'(PLAYER_X) && {1'b0, xpos} < 11'(PLAYER_X + PLAYER_SIZE) &&
                     ypos >= player_y && {1'b0, ypos} < {1'b0, player_y} + 11'(PLAYER_SIZE);
  assign in_wall   = xpos >= wall_x && {1'b0, xpos} < {1'b0, wall_x} + 11'(WALL_W) &&
                     (ypos < gap_y || {1'b0, ypos} >= {1'b0, gap_y} + 11'(GAP_H));

  always_comb begin
    pix = RGB_BLACK;
    if (out_en && visible) begin
      case (state)
        IDLE: pix = RGB_BLUE;
        PLAY: begin
          if (in_player)    pix = RGB_RED;
          else if (in_wall) pix = RGB_GREEN;
        end
        OVER:    pix = RGB_RED;
        default: pix = RGB_BLACK;
      endcase
    end
  end

  assign red   = pix.r;
  assign green = pix.g;
  assign blue  = pix.b;

endmodule

// File: tb/tb_pitch_game_top.sv
// Bench for pitch_game_top on a shrunken raster so whole games fit in a short run.
// Raster and game behaviour are predicted from elapsed cycles and the game rules.
module tb_pitch_game_top;

  localparam int H = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int V = 48, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = H + HFP + HS + HBP;
  localparam int VT = V + VFP + VS + VBP;
  localparam int WIN = 100, PSH = 2, PX = 20, PS = 4, WW = 4, GH = 8, GMIN = 4;
  localparam int FLOOR = V - 1 - PS;
  localparam int SPAN = V - GH - 2 * GMIN;
  localparam logic [11:0] BLACK = 12'h000, RED = 12'hF00, GREEN = 12'h0F0, BLUE = 12'h00F;

  logic clk = 1'b0, resetNot = 1'b0, start_button_not = 1'b1, mic_clk = 1'b0;
  logic [9:0] xpos, ypos;
  logic hsync, vsync;
  logic [3:0] red, green, blue;
  int checks = 0, failures = 0, cyc = 0, mic_per = 0;

  pitch_game_top #(
    .H_VISIBLE(H), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(V), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .WINDOW_CYCLES(WIN), .PITCH_SHIFT(PSH), .PLAYER_X(PX), .PLAYER_SIZE(PS),
    .WALL_W(WW), .GAP_H(GH), .GAP_MIN(GMIN)
  ) dut (
    .clk(clk), .resetNot(resetNot), .start_button_not(start_button_not), .mic_clk(mic_clk),
    .xpos(xpos), .ypos(ypos), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // Clocks elapsed since reset release; the raster position is half of it.
  always @(posedge clk or negedge resetNot)
    if (!resetNot) cyc <= 0;
    else           cyc <= cyc + 1;

  initial begin : mic_gen
    int p;
    forever begin
      if (mic_per == 0) begin
        mic_clk = 1'b0;
        @(negedge clk);
      end else begin
        p = mic_per;
        mic_clk = 1'b1;
        repeat (p / 2) @(negedge clk);
        mic_clk = 1'b0;
        repeat (p - p / 2) @(negedge clk);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int t, ex, ey;
    @(negedge clk);
    t  = cyc / 2;
    ex = t % HT;
    ey = (t / HT) % VT;
    chk("xpos", 32'(xpos), ex);
    chk("ypos", 32'(ypos), ey);
    chk("hsync", 32'(hsync), 32'(!(ex >= H + HFP && ex < H + HFP + HS)));
    chk("vsync", 32'(vsync), 32'(!(ey >= V + VFP && ey < V + VFP + VS)));
    if (ex >= H || ey >= V) chk("blank", 32'({red, green, blue}), 0);
  endtask

  task automatic wait_pixel(input int x, input int y);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(xpos == 10'(x) && ypos == 10'(y)) && n < 2 * HT * VT + 4);
    chk("reach_pixel", 32'(xpos == 10'(x) && ypos == 10'(y)), 1);
  endtask

  task automatic press();
    start_button_not = 1'b0;
    repeat (4) step();
    start_button_not = 1'b1;
    repeat (4) step();
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    chk(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  initial begin
    int p, pc, lo, hi, lows, wx, gap, py, frames;
    bit over;

    repeat (3) @(negedge clk);
    chk("rst_xpos", 32'(xpos), 0);
    chk("rst_ypos", 32'(ypos), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk_rgb("rst_rgb", BLACK);
    resetNot = 1'b1;
    repeat (6) step();

    wait_pixel(HT - 1, 0);
    step();
    step();
    chk("x_wrap", 32'(xpos), 0);
    chk("y_inc", 32'(ypos), 1);
    lows = 0;
    repeat (2 * HT) begin step(); if (!hsync) lows++; end
    chk("hsync_low_clks", lows, 2 * HS);
    lows = 0;
    repeat (2 * HT * VT) begin step(); if (!vsync) lows++; end
    chk("vsync_low_clks", lows, 2 * HT * VS);

    wait_pixel(10, 10);
    chk_rgb("idle_blue", BLUE);

    for (int i = 0; i < 4; i++) begin
      p = $urandom_range(30, 4);
      mic_per = p;
      repeat (300) step();
      pc = 32'(dut.pitch_count);
      lo = WIN / p;
      hi = (WIN + p - 1) / p;
      checks++;
      assert (pc === lo || pc === hi) else begin
        failures++;
        $error("FAIL pitch_rand period=%0d observed=%0d expected=%0d or %0d", p, pc, lo, hi);
      end
    end
    mic_per = 10;
    repeat (300) step();
    chk("pitch_10", 32'(dut.pitch_count), 10);

    py = FLOOR - ((10 << PSH) < FLOOR ? (10 << PSH) : FLOOR);
    wait_pixel(0, V + 1);
    press();
    wait_pixel(PX, py - 1);
    chk_rgb("above_player", BLACK);
    wait_pixel(PX - 1, py);
    chk_rgb("left_of_player", BLACK);
    wait_pixel(PX, py);
    chk_rgb("player_tl", RED);
    wait_pixel(PX + PS, py);
    chk_rgb("right_of_player", BLACK);
    wait_pixel(PX + PS - 1, py + PS - 1);
    chk_rgb("player_br", RED);
    wait_pixel(10, 10);
    chk_rgb("play_black", BLACK);

    @(negedge clk);
    #1 resetNot = 1'b0;
    #1;
    chk("midrst_xpos", 32'(xpos), 0);
    chk("midrst_ypos", 32'(ypos), 0);
    chk("midrst_hsync", 32'(hsync), 1);
    chk("midrst_vsync", 32'(vsync), 1);
    chk_rgb("midrst_rgb", BLACK);
    chk("midrst_pitch", 32'(dut.pitch_count), 0);
    repeat (3) @(negedge clk);
    resetNot = 1'b1;
    wait_pixel(10, 10);
    chk_rgb("after_rst_idle", BLUE);

    mic_per = 0;
    repeat (300) step();
    chk("pitch_silent", 32'(dut.pitch_count), 0);
    wx = H - 1;
    gap = GMIN + (8'hA5 % SPAN);
    py = FLOOR;
    over = 1'b0;
    frames = 0;
    wait_pixel(0, V + 1);
    press();
    while (frames < 20) begin
      wait_pixel(wx, 0);
      chk_rgb("wall_px", over ? RED : GREEN);
      wait_pixel(1, 1);
      chk_rgb("bg_px", over ? RED : BLACK);
      wait_pixel(PX, py);
      chk_rgb("floor_player", RED);
      if (over) break;
      wait_pixel(0, V + 1);
      if (wx < PX + PS && wx + WW > PX && (py < gap || py + PS > gap + GH)) over = 1'b1;
      wx = (wx == 0) ? H - 1 : wx - 1;
      frames++;
    end

    wait_pixel(0, V + 1);
    press();
    wait_pixel(10, 10);
    chk_rgb("over_to_idle", BLUE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pitch_game_top.md
Name: pitch_game_top

Overview:
- Top level of a voice-controlled VGA game.
- A digital pitch waveform from the microphone front end (mic_clk) is frequency-counted. The count sets the vertical position of a player square, which must fly through the gap of a wall scrolling left.
- Drives 640x480 VGA timing and 12-bit colour, and exports the pixel counters.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths in pixels
- V_VISIBLE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths in lines
- WINDOW_CYCLES, 1048576, clk cycles per pitch-measurement window
- PITCH_SHIFT, 2, left shift applied to edge count to get height in pixels
- PLAYER_X, 100, player square left column
- PLAYER_SIZE, 16, player square side
- WALL_W, 16, wall width
- GAP_H, 128, wall gap height

Ports:
- clk  in  1  system clock; pixel rate = clk/2
- resetNot  in  1  asynchronous active-low reset
- start_button_not  in  1  start push-button, active-low, asynchronous to clk
- mic_clk  in  1  pitch square wave; data input, NOT a clock; sampled in clk domain
- xpos  out  10  horizontal pixel counter 0..799
- ypos  out  10  vertical line counter 0..524
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- red  out  4  red intensity
- green  out  4  green intensity
- blue  out  4  blue intensity

Behaviour:
- Single clock domain (clk). All flops use asynchronous reset on resetNot low.
- Reset values:
  - xpos=0, ypos=0, hsync=1, vsync=1, rgb=0.
  - pix_en=0; state=IDLE.
  - pitch_count=0, edge counter=0, window counter=0.
  - wall_x=639, gap_y=176, LFSR=8'hA5.
- Pixel timing:
  - pix_en toggles every clk. Counters advance only when pix_en=1.
  - xpos wraps 799->0 and increments ypos; ypos wraps 524->0.
- Sync: hsync=0 iff 656<=xpos<=751; vsync=0 iff 490<=ypos<=491. Combinational from counters, zero latency vs xpos/ypos.
- Blanking: rgb=0 when xpos>=640 or ypos>=480.
- Start button:
  - 2-flop synchroniser on start_button_not.
  - press = synced high->low transition; one-clk pulse.
- Pitch measurement:
  - 2-flop synchroniser on mic_clk; rising edge detected on the synced signal.
  - Edges are counted (16-bit, saturating) over WINDOW_CYCLES clk cycles.
  - At window end: pitch_count <= count, and the counter clears. The window end and an edge in the same cycle count toward the new window.
- Player position:
  - h = min(pitch_count<<PITCH_SHIFT, 479-PLAYER_SIZE).
  - player_y = 479-PLAYER_SIZE-h, so silence puts the player on the floor.
- Frame tick: one-clk pulse when pix_en=1 and xpos=0, ypos=480.
- FSM:
  - IDLE: press -> PLAY. Entering PLAY resets wall_x=639, gap_y from LFSR.
  - PLAY, on each frame tick:
    - wall_x decrements by 1.
    - When wall_x=0, it wraps to 639, the LFSR steps (taps 8,6,5,4), and gap_y = 32 + (lfsr mod 288).
    - Collision check uses the tick's pre-update values. Collision = player box [PLAYER_X, PLAYER_X+PLAYER_SIZE) x [player_y, player_y+PLAYER_SIZE) overlaps wall columns [wall_x, wall_x+WALL_W) outside rows [gap_y, gap_y+GAP_H). Collision -> OVER.
  - OVER: press -> IDLE.
  - Reset mid-game returns to IDLE immediately.
- Colours (visible area), combinational from counters and registered state:
  - IDLE: full screen blue (0,0,F).
  - PLAY:
    - player square red (F,0,0), highest priority;
    - wall solid region green (0,F,0);
    - else black.
  - OVER: full screen red (F,0,0).

Decomposition:
- Package pitch_game_pkg: state enum {IDLE, PLAY, OVER}; VGA timing constants; colour constants.
- Natural sub-module: vga_timing (pix_en, counters, sync).
- Pitch counter, FSM and pixel colour logic stay in the top.

Test Plan:
- Reset held low -> xpos=ypos=0, hsync=vsync=1, rgb=0; release -> xpos increments every 2 clk.
- Run one line -> hsync low for exactly xpos 656..751 (192 clk); xpos wraps 799->0 and ypos increments. Run one frame -> vsync low on ypos 490..491.
- IDLE, pixel (10,10) -> rgb=0,0,F. Pulse start_button_not low 4 clk -> state PLAY; same pixel -> 0,0,0.
- WINDOW_CYCLES=100, mic_clk period 10 clk -> pitch_count=10, player_y=479-16-40=423. Pixel (100,423) -> F,0,0.
- mic_clk idle, gap placed away from floor, many frame ticks -> wall reaches PLAYER_X, state OVER, full-screen red. Press -> IDLE blue.
- Assert resetNot low during PLAY -> immediate IDLE, counters 0, outputs at reset values.
